ped_req_gen: RTL

PED_REQ_GEN -- requirements
Module: ped_req_gen

---
 rtl/ped_req_gen.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/ped_req_gen.sv
// Pedestrian request generator: synchronizes and debounces two push buttons,
// latches presses as pending flags and serializes them into spaced request pulses.
module ped_req_gen #(
    parameter int CLK_HZ      = 25_000_000,
    parameter int DEBOUNCE_MS = 20,
    parameter int PULSE_CYC   = 4,
    parameter int GAP_CYC     = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_ns,
    input  logic btn_ew,
    output logic ped_NS_req,
    output logic ped_EW_req,
    output logic ns_pending,
    output logic ew_pending
);

    localparam int DB_RAW = (CLK_HZ / 1000) * DEBOUNCE_MS;
    localparam int DB_CYC = (DB_RAW < 1) ? 1 : DB_RAW;
    localparam int DB_W   = $clog2(DB_CYC + 1);
    localparam int EC_MAX = (PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC;
    localparam int EC_W   = $clog2(EC_MAX + 1);

    localparam logic [DB_W-1:0] DB_LAST    = DB_W'(DB_CYC - 1);
    localparam logic [EC_W-1:0] PULSE_LAST = EC_W'(PULSE_CYC - 1);
    // The IDLE decision cycle supplies the final low cycle of the gap.
    localparam logic [EC_W-1:0] GAP_LAST   = EC_W'(GAP_CYC - 2);

    typedef enum logic [1:0] {E_IDLE, E_PULSE, E_GAP} e_state_t;

    // Channel index 0 is NS, index 1 is EW throughout.
    logic [1:0]      btn_raw;
    logic [1:0]      sync_p0, sync_p1;
    logic [1:0]      db_p2, db_dly, press_p3;
    logic [1:0]      pend, clr;
    logic [DB_W-1:0] db_cnt [2];

    e_state_t        state, state_nx;
    logic            sel_ew, sel_ew_nx;
    logic [EC_W-1:0] ecnt, ecnt_nx;

    assign btn_raw = {btn_ew, btn_ns};

    // Stage p0/p1: two-flop synchronizers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
        end else begin
            sync_p0 <= btn_raw;
            sync_p1 <= sync_p0;
        end
    end

    // Stage p2/p3: debounce, then rising-edge detect of the debounced level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_p2    <= '0;
            db_dly   <= '0;
            press_p3 <= '0;
            for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
        end else begin
            db_dly   <= db_p2;
            press_p3 <= db_p2 & ~db_dly;
            for (int i = 0; i < 2; i++) begin
                if (sync_p1[i] == db_p2[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    db_cnt[i] <= '0;
                    db_p2[i]  <= sync_p1[i];
                end else begin
                    db_cnt[i] <= db_cnt[i] + DB_W'(1);
                end
            end
        end
    end

    // A press landing on the same edge as the emitter's clear keeps the flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend <= '0;
        end else begin
            pend <= (pend & ~clr) | press_p3;
        end
    end

    assign ns_pending = pend[0];
    assign ew_pending = pend[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= E_IDLE;
            sel_ew     <= 1'b0;
            ecnt       <= '0;
            ped_NS_req <= 1'b0;
            ped_EW_req <= 1'b0;
        end else begin
            state      <= state_nx;
            sel_ew     <= sel_ew_nx;
            ecnt       <= ecnt_nx;
            ped_NS_req <= (state_nx == E_PULSE) && !sel_ew_nx;
            ped_EW_req <= (state_nx == E_PULSE) && sel_ew_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        sel_ew_nx = sel_ew;
        ecnt_nx   = ecnt;
        clr       = '0;
        case (state)
            E_IDLE: begin
                ecnt_nx = '0;
                if (pend[0]) begin
                    sel_ew_nx = 1'b0;
                    clr       = 2'b01;
                    state_nx  = E_PULSE;
                end else if (pend[1]) begin
                    sel_ew_nx = 1'b1;
                    clr       = 2'b10;
                    state_nx  = E_PULSE;
                end
            end
            E_PULSE: begin
                if (ecnt == PULSE_LAST) begin
                    ecnt_nx  = '0;
                    state_nx = E_GAP;
                end else begin
                    ecnt_nx = ecnt + EC_W'(1);
                end
            end
            E_GAP: begin
                if (ecnt == GAP_LAST) begin
                    ecnt_nx  = '0;
                    state_nx = E_IDLE;
                end else begin
                    ecnt_nx = ecnt + EC_W'(1);
                end
            end
            default: state_nx = E_IDLE;
        endcase
    end

endmodule
